// File: rtl/mux_src_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux_src_arbiter_if
// Handshake bundle between two 4-bit source channels (A, B), the arbiter and
// the downstream select mux.
//   a_valid/a_data/a_ready  : channel A valid/ready handshake
//   b_valid/b_data/b_ready  : channel B valid/ready handshake
//   out_valid/out_data/out_sel/out_ready : registered output handshake,
//                             out_sel = 0 -> word from A, 1 -> word from B
// Modports:
//   master : the side that drives the sources and accepts the output
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface mux_src_arbiter_if;
  logic       a_valid;
  logic [3:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [3:0] b_data;
  logic       b_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_sel;
  logic       out_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_src_arbiter.sv
// ---------------------------------------------------------------------------
// mux_src_arbiter
// Upstream stage of the 4-bit 2:1 select mux. Picks one of two 4-bit source
// channels with a bounded-burst round-robin policy and registers the chosen
// word together with the select bit that identifies its origin.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : mux_src_arbiter_if.slave (A/B source handshakes, output handshake)
// Parameters:
//   BURST_LEN : max consecutive grants to one channel under contention (1..15)
//   CNT_W     : burst counter width, 2**CNT_W > BURST_LEN
// ---------------------------------------------------------------------------
module mux_src_arbiter #(
  parameter int unsigned BURST_LEN = 2,
  parameter int unsigned CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux_src_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LP_BURST = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

  logic             r_out_valid;
  logic [3:0]       r_out_data;
  logic             r_out_sel;
  logic             r_last_sel;
  logic [CNT_W-1:0] r_burst_cnt;

  logic             w_load_en;
  logic             w_grant_vld;
  logic             w_grant;
  logic [3:0]       w_data;
  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_xfer;

  // The output register may reload in the same cycle its current word drains.
  assign w_load_en = !r_out_valid || bus.out_ready;

  // Grant selection: a lone requester always wins; under contention the
  // current owner keeps the grant until it has used up its burst allowance.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = 1'b0;
    case ({bus.a_valid, bus.b_valid})
      2'b10: begin
        w_grant_vld = 1'b1;
        w_grant     = 1'b0;
      end
      2'b01: begin
        w_grant_vld = 1'b1;
        w_grant     = 1'b1;
      end
      2'b11: begin
        w_grant_vld = 1'b1;
        if (r_burst_cnt >= LP_BURST) begin
          w_grant = !r_last_sel;
        end else begin
          w_grant = r_last_sel;
        end
      end
      default: begin
        w_grant_vld = 1'b0;
        w_grant     = 1'b0;
      end
    endcase
  end

  // Ready is suppressed during reset so the reset cycle never accepts a word.
  assign w_a_ready = !rst && w_load_en && w_grant_vld && !w_grant;
  assign w_b_ready = !rst && w_load_en && w_grant_vld &&  w_grant;
  assign w_xfer    = (bus.a_valid && w_a_ready) || (bus.b_valid && w_b_ready);
  assign w_data    = w_grant ? bus.b_data : bus.a_data;

  // Output register stage and burst bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 4'h0;
      r_out_sel   <= 1'b0;
      // Pretend B just finished a full burst so the first contested grant is A.
      r_last_sel  <= 1'b1;
      r_burst_cnt <= LP_BURST;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_sel   <= w_grant;
      if (w_grant == r_last_sel) begin
        // Saturate so a solo channel is never throttled.
        if (r_burst_cnt >= LP_BURST) begin
          r_burst_cnt <= LP_BURST;
        end else begin
          r_burst_cnt <= r_burst_cnt + LP_ONE;
        end
      end else begin
        r_last_sel  <= w_grant;
        r_burst_cnt <= LP_ONE;
      end
    end else if (r_out_valid && bus.out_ready) begin
      // Drain only; the word and select stay visible for the mux.
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign bus.a_ready   = w_a_ready;
  assign bus.b_ready   = w_b_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_src_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_src_arbiter
// Directed scenarios with literal expectations followed by a randomized run.
// A grant-history model (queue of past grants, run length computed on the
// fly) predicts readies and the output register every cycle.
// ---------------------------------------------------------------------------
module tb_mux_src_arbiter;
  localparam int BL = 2;

  logic clk;
  logic rst;
  bit   chk_en;
  int   n_cmp;
  int   n_err;

  mux_src_arbiter_if bus ();

  mux_src_arbiter #(.BURST_LEN(BL), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_valid;
  bit [3:0] m_data;
  bit       m_sel;
  bit       hist[$];   // past grants, 0 = A, 1 = B

  function automatic int run_len();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size()-1]) n++;
      else break;
    end
    return n;
  endfunction

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    bit load, gv, g, ea, eb;
    load = !m_valid || bus.out_ready;
    gv   = bus.a_valid || bus.b_valid;
    if (bus.a_valid && bus.b_valid)
      g = (run_len() >= BL) ? !hist[hist.size()-1] : hist[hist.size()-1];
    else
      g = bus.b_valid;
    ea = !rst && load && gv && !g;
    eb = !rst && load && gv &&  g;
    if (chk_en) begin
      chk("a_ready",   {7'd0, bus.a_ready},   {7'd0, ea});
      chk("b_ready",   {7'd0, bus.b_ready},   {7'd0, eb});
      chk("out_valid", {7'd0, bus.out_valid}, {7'd0, m_valid});
      chk("out_data",  {4'd0, bus.out_data},  {4'd0, m_data});
      chk("out_sel",   {7'd0, bus.out_sel},   {7'd0, m_sel});
    end
    if (rst) begin
      m_valid = 1'b0; m_data = 4'h0; m_sel = 1'b0;
      hist.delete();
      for (int i = 0; i < BL; i++) hist.push_back(1'b1);
    end else if (ea || eb) begin
      m_valid = 1'b1;
      m_data  = g ? bus.b_data : bus.a_data;
      m_sel   = g;
      hist.push_back(g);
      if (hist.size() > 32) void'(hist.pop_front());
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input logic [3:0] ad, input bit bv,
                       input logic [3:0] bd, input bit ordy);
    bus.a_valid = av; bus.a_data = ad;
    bus.b_valid = bv; bus.b_data = bd;
    bus.out_ready = ordy;
  endtask

  task automatic chk_out(input string name, input bit v, input logic [3:0] d, input bit s);
    chk({name, ".valid"}, {7'd0, bus.out_valid}, {7'd0, v});
    chk({name, ".data"},  {4'd0, bus.out_data},  {4'd0, d});
    chk({name, ".sel"},   {7'd0, bus.out_sel},   {7'd0, s});
  endtask

  initial begin
    bit [5:0]  exp_sel;
    logic [3:0] exp_data [6];
    n_cmp = 0; n_err = 0; chk_en = 1'b0;
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    step(); step();
    chk_en = 1'b1;
    #1;
    chk_out("reset", 1'b0, 4'h0, 1'b0);

    // Continuous contention
    rst = 1'b0;
    drive(1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
    #1;
    chk("cont.first_a_ready", {7'd0, bus.a_ready}, 8'd1);
    chk("cont.first_b_ready", {7'd0, bus.b_ready}, 8'd0);
    chk("cont.no_early_valid", {7'd0, bus.out_valid}, 8'd0);
    exp_sel = 6'b001100;   // index 0 is LSB: 0,0,1,1,0,0
    exp_data[0] = 4'h3; exp_data[1] = 4'h3; exp_data[2] = 4'hC;
    exp_data[3] = 4'hC; exp_data[4] = 4'h3; exp_data[5] = 4'h3;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out($sformatf("cont[%0d]", i), 1'b1, exp_data[i], exp_sel[i]);
    end

    // Backpressure: hold for three cycles, burst state frozen
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp.a_ready", {7'd0, bus.a_ready}, 8'd0);
      chk("bp.b_ready", {7'd0, bus.b_ready}, 8'd0);
      chk_out($sformatf("bp[%0d]", i), 1'b1, 4'h3, 1'b0);
      if (i < 2) step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release_b_ready", {7'd0, bus.b_ready}, 8'd1);
    step();
    chk_out("bp.after", 1'b1, 4'hC, 1'b1);

    // Solo B for five transfers, then A joins
    drive(1'b0, 4'h0, 1'b1, 4'h5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("solo[%0d]", i), 1'b1, 4'h5, 1'b1);
    end
    drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1);
    step(); chk_out("join[0]", 1'b1, 4'hA, 1'b0);
    step(); chk_out("join[1]", 1'b1, 4'hA, 1'b0);
    step(); chk_out("join[2]", 1'b1, 4'h5, 1'b1);

    // Pass-through with drain
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    step();
    drive(1'b1, 4'h9, 1'b0, 4'h0, 1'b1);
    step();
    bus.a_valid = 1'b0;
    chk_out("pass.load", 1'b1, 4'h9, 1'b0);
    step();
    chk_out("pass.drain", 1'b0, 4'h9, 1'b0);

    // Simultaneous drain and load
    drive(1'b1, 4'h2, 1'b0, 4'h0, 1'b1);
    step();
    drive(1'b0, 4'h0, 1'b1, 4'h7, 1'b1);
    #1;
    chk("sdl.b_ready", {7'd0, bus.b_ready}, 8'd1);
    step();
    chk_out("sdl.next", 1'b1, 4'h7, 1'b1);

    // Reset mid-stream
    drive(1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
    step(); step();
    rst = 1'b1;
    #1;
    chk("rst.a_ready", {7'd0, bus.a_ready}, 8'd0);
    chk("rst.b_ready", {7'd0, bus.b_ready}, 8'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst.out_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("rst.first_a_ready", {7'd0, bus.a_ready}, 8'd1);
    step();
    chk_out("rst.first", 1'b1, 4'h3, 1'b0);

    // Randomized run, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60, 4'($urandom), $urandom_range(0, 99) < 60,
            4'($urandom), $urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
